regfile_arbiter: RTL
====================

Name: regfile_arbiter

Overview:
- Controller that shares one single-port register file (CLK, RSTn, ADDR, WE, DIN, DOUT) between two requesters, A and B.
- Clears the register file to zero after reset and on CLR using an init sweep.
- In RUN it does round-robin arbitration, issuing one command per cycle, and routes read data back to the owner of each read.
- Sits between the two clients and the regfile instance.

Parameters:
- AW, 2, register-file address width; depth = 2^AW.
- DW, 4, register-file data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RSTn  in  1  asynchronous active-low reset.
- CLR  in  1  level, sampled on posedge; starts the init sweep.
- A_REQ  in  1  A has a command this cycle.
- A_WE  in  1  1 = write, 0 = read.
- A_ADDR  in  AW  A address.
- A_DIN  in  DW  A write data.
- A_GNT  out  1  A command accepted this cycle (combinational).
- A_RVALID  out  1  A read data valid, 1-cycle pulse.
- A_RDATA  out  DW  A read data.
- B_REQ, B_WE, B_ADDR, B_DIN, B_GNT, B_RVALID, B_RDATA: same as A, for requester B.
- RF_ADDR  out  AW  to regfile ADDR (registered).
- RF_WE  out  1  to regfile WE (registered).
- RF_DIN  out  DW  to regfile DIN (registered).
- RF_DOUT  in  DW  from regfile DOUT.
- BUSY  out  1  init sweep in progress.

Behaviour:
- Regfile contract: write at posedge when WE=1; DOUT = mem[ADDR] combinationally.
- Reset (RSTn=0, async):
  - state=INIT, sweep pointer=0, LAST=B so A wins the first tie, read pipeline cleared.
  - All outputs 0 except BUSY=1.
- INIT sweep:
  - The first posedge after RSTn rises loads RF_WE=1, RF_ADDR=0, RF_DIN=0.
  - Each following edge increments RF_ADDR, up to 2^AW-1.
  - The edge after the write to 2^AW-1 loads RF_WE=0, BUSY=0 and moves to RUN.
  - Sweep takes exactly 2^AW cycles with RF_WE=1.
  - A_GNT and B_GNT stay 0 throughout INIT.
- Grant logic in RUN, with CLR=0:
  - Only one requesting: that requester gets GNT.
  - Both requesting: grant goes to the one not equal to LAST.
  - LAST updates at each edge where a handshake (REQ & GNT) occurs.
- Command stage:
  - On a handshake edge, RF_ADDR/RF_WE/RF_DIN load the winner's ADDR/WE/DIN.
  - With no handshake, RF_WE loads 0; RF_ADDR and RF_DIN hold.
- Read return:
  - An accepted read also loads pend=1 and owner.
  - In the following cycle RF_DOUT is valid and is registered into owner's RDATA at the next edge, with owner's RVALID=1 for one cycle.
  - Handshake-to-RVALID latency is 2 cycles.
  - RDATA holds between pulses.
  - Writes produce no response.
  - Throughput: one command per cycle; back-to-back reads return in order on consecutive cycles.
- Hazard: a write followed by a read of the same address on the next cycle (either requester) returns the new data, because the write commits before the read command is driven.
- CLR:
  - CLR=1 forces both GNT to 0 in the same cycle.
  - The next edge enters INIT with pointer 0 and BUSY=1.
  - A read already on RF_* still completes and delivers its RVALID.
  - CLR during INIT restarts the sweep at 0.
- RSTn asserted mid-operation: in-flight reads are dropped with no RVALID; RF_WE goes to 0 immediately.
- RF_ADDR and sweep pointer arithmetic are AW bits wide; the sweep terminates on pointer == 2^AW-1 and does not wrap.

Decomposition:
- Package regfile_arb_pkg:
  - state enum {ST_INIT, ST_RUN};
  - owner enum {OWN_A, OWN_B};
  - default AW and DW constants.
- Sub-module rr_arb2: 2-way round-robin grant logic with the LAST register and an enable input (state==RUN & !CLR).
- Sweep counter, command registers and read-return pipeline stay in the top module.

Test Plan:
- Release RSTn, AW=2 -> RF_WE=1 with RF_ADDR=0,1,2,3 on 4 consecutive cycles, RF_DIN=0; BUSY falls with RF_WE; both GNT=0 throughout.
- A writes addr1=4'h5, then A reads addr1 -> A_GNT=1 in the request cycle; next cycle RF_WE=1, RF_ADDR=1, RF_DIN=5; A_RVALID pulses 2 cycles after the read handshake with A_RDATA=4'h5; B_RVALID stays 0.
- A and B both hold REQ; A writes 4'h3 to addr0, B reads addr0 -> grants alternate A,B,A,B starting with A; B_RDATA=4'h3.
- B reads addr2 (4'h7) then A reads addr3 (4'h9) back-to-back -> B_RVALID with 4'h7 then A_RVALID with 4'h9 on consecutive cycles; no cross-routing.
- 1-cycle CLR pulse with both requesting after addr1=4'h5 -> both GNT=0, 4-cycle sweep, BUSY=1 during the sweep; a subsequent A read of addr1 returns 4'h0.
- RSTn pulled low 1 cycle after a read handshake -> RVALID never asserts; RF_WE=0 immediately; the sweep restarts at addr0 after release.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the two-client register-file arbiter.
// Imported by the top and the round-robin grant sub-module.
package regfile_arb_pkg;

    localparam int AW_DEF = 2;
    localparam int DW_DEF = 4;

    typedef enum logic {ST_INIT, ST_RUN} state_e;
    typedef enum logic {OWN_A, OWN_B} owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is granted.
// The LAST register moves only on an edge where a grant (and therefore a handshake) occurs.
module rr_arb2
    import regfile_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    owner_e last_q, last_d;

    always_comb begin
        a_gnt  = en & a_req & (~b_req | (last_q == OWN_B));
        b_gnt  = en & b_req & (~a_req | (last_q == OWN_A));
        last_d = last_q;
        if (a_gnt) begin
            last_d = OWN_A;
        end else if (b_gnt) begin
            last_d = OWN_B;
        end
    end

    // Reset value OWN_B lets A win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one single-port register file between clients A and B: zero-fill sweep after
// reset or CLR, then one round-robin command per cycle with read data routed to its owner.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          CLR,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_DIN,
    output logic          A_GNT,
    output logic          A_RVALID,
    output logic [DW-1:0] A_RDATA,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_DIN,
    output logic          B_GNT,
    output logic          B_RVALID,
    output logic [DW-1:0] B_RDATA,
    output logic [AW-1:0] RF_ADDR,
    output logic          RF_WE,
    output logic [DW-1:0] RF_DIN,
    input  logic [DW-1:0] RF_DOUT,
    output logic          BUSY
);

    localparam logic [AW-1:0] PTR_MAX = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic          rf_we_q, rf_we_d;
    logic [DW-1:0] rf_din_q, rf_din_d;
    logic          pend_q, pend_d;
    owner_e        owner_q, owner_d;
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          arb_en;

    // Handshake: a command transfers on the edge where REQ & GNT. GNT is combinational and
    // may be withheld any cycle, so a client holds REQ and its WE/ADDR/DIN stable until then.
    assign arb_en = (state_q == ST_RUN) & ~CLR;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RSTn),
        .en    (arb_en),
        .a_req (A_REQ),
        .b_req (B_REQ),
        .a_gnt (A_GNT),
        .b_gnt (B_GNT)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rf_addr_d  = rf_addr_q;
        rf_we_d    = 1'b0;
        rf_din_d   = rf_din_q;
        pend_d     = 1'b0;
        owner_d    = owner_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        // A read driven last cycle returns regardless of CLR.
        if (pend_q) begin
            if (owner_q == OWN_A) begin
                a_rvalid_d = 1'b1;
                a_rdata_d  = RF_DOUT;
            end else begin
                b_rvalid_d = 1'b1;
                b_rdata_d  = RF_DOUT;
            end
        end

        if (CLR) begin
            state_d = ST_INIT;
            ptr_d   = '0;
        end else if (state_q == ST_INIT) begin
            if (rf_we_q && (rf_addr_q == PTR_MAX)) begin
                state_d = ST_RUN;
            end else begin
                rf_we_d   = 1'b1;
                rf_addr_d = ptr_q;
                rf_din_d  = '0;
                if (ptr_q != PTR_MAX) begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        end else if (A_GNT) begin
            rf_we_d   = A_WE;
            rf_addr_d = A_ADDR;
            rf_din_d  = A_DIN;
            pend_d    = ~A_WE;
            owner_d   = OWN_A;
        end else if (B_GNT) begin
            rf_we_d   = B_WE;
            rf_addr_d = B_ADDR;
            rf_din_d  = B_DIN;
            pend_d    = ~B_WE;
            owner_d   = OWN_B;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            rf_addr_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_din_q   <= '0;
            pend_q     <= 1'b0;
            owner_q    <= OWN_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rf_addr_q  <= rf_addr_d;
            rf_we_q    <= rf_we_d;
            rf_din_q   <= rf_din_d;
            pend_q     <= pend_d;
            owner_q    <= owner_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign RF_ADDR  = rf_addr_q;
    assign RF_WE    = rf_we_q;
    assign RF_DIN   = rf_din_q;
    assign A_RVALID = a_rvalid_q;
    assign A_RDATA  = a_rdata_q;
    assign B_RVALID = b_rvalid_q;
    assign B_RDATA  = b_rdata_q;
    assign BUSY     = (state_q == ST_INIT);

endmodule
